// File: rtl/shift_pkg.sv
// Shared types for the load/shift register command sequencer.
// Op encodings, controller states and default datapath sizes.
package shift_pkg;

   localparam int SHIFT_WIDTH = 4;
   localparam int SHIFT_CNT_W = 3;

   typedef enum logic [1:0] {
      SHIFT_OP_LOAD     = 2'b00,
      SHIFT_OP_SHR      = 2'b01,
      SHIFT_OP_SHL      = 2'b10,
      SHIFT_OP_LOAD_SHL = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } shift_state_t;

   function automatic logic op_loads(input shift_op_t op);
      return (op == SHIFT_OP_LOAD) || (op == SHIFT_OP_LOAD_SHL);
   endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a load/shift register one control per cycle.
// Register controls are Moore outputs decoded from the state register.
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH,
   parameter int CNT_W = SHIFT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  shift_op_t        cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             abort,
   output logic             reg_ld,
   output logic             reg_s_cnt,
   output logic             reg_sr,
   output logic             reg_sl,
   output logic [WIDTH-1:0] reg_d_in,
   input  logic [WIDTH-1:0] reg_q,
   output logic             done,
   output logic             aborted,
   output logic [WIDTH-1:0] result
);

   shift_state_t     state_q, state_d;
   shift_op_t        op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abrt_q, abrt_d;
   logic [WIDTH-1:0] result_q;
   logic             accept;

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         abrt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         abrt_q  <= abrt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= SHIFT_OP_LOAD;
         data_q <= '0;
      end else if (accept) begin
         op_q   <= cmd_op;
         data_q <= cmd_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abrt_d  = abrt_q;
      unique case (state_q)
         ST_IDLE: begin
            abrt_d = 1'b0;
            if (cmd_valid) begin
               cnt_d = cmd_cnt;
               if (op_loads(cmd_op))
                  state_d = ST_LOAD;
               else if (cmd_cnt != '0)
                  state_d = ST_SHIFT;
               else
                  state_d = ST_DONE;
            end
         end
         ST_LOAD: begin
            if (op_q == SHIFT_OP_LOAD_SHL && cnt_q != '0)
               state_d = ST_SHIFT;
            else
               state_d = ST_DONE;
         end
         ST_SHIFT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // an abort on the final shift is not a truncation
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end else if (abort) begin
               abrt_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      reg_ld    = 1'b0;
      reg_s_cnt = 1'b0;
      reg_sr    = 1'b0;
      reg_sl    = 1'b0;
      reg_d_in  = '0;
      done      = 1'b0;
      aborted   = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            reg_ld   = 1'b1;
            reg_d_in = data_q;
         end
         ST_SHIFT: begin
            reg_s_cnt = 1'b1;
            reg_sr    = (op_q == SHIFT_OP_SHR);
            reg_sl    = (op_q != SHIFT_OP_SHR);
         end
         ST_DONE: begin
            done    = 1'b1;
            aborted = abrt_q;
         end
         default: ;
      endcase
   end

   // The register settles on the edge entering DONE, so reg_q is final there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         result_q <= '0;
      else if (state_q == ST_DONE)
         result_q <= reg_q;
   end

   assign result = (state_q == ST_DONE) ? reg_q : result_q;

endmodule
